// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin muxing arbiter.
// Holds the arbitration state enum and the rotate helper used by rr_pick.
package mux_rr_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Rotate the low n bits of v left by sh (sh may equal n). Bits at n and above stay zero.
  function automatic logic [31:0] rotl(input logic [31:0] v, input int sh, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < n) r[(i + sh) % n] = v[i];
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational round-robin picker: rotate so ptr sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick
  import mux_rr_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [31:0] rot;
  int          pos;
  logic        found;

  always_comb begin
    rot   = rotl(32'(req), N - int'(ptr), N);
    pos   = 0;
    found = 1'b0;
    for (int j = 0; j < 32; j++)
      if (!found && rot[j]) begin
        pos   = j;
        found = 1'b1;
      end
    idx   = IW'((pos + int'(ptr)) % N);
    grant = '0;
    if (found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin N:1 arbiter feeding one registered valid/ready output slot.
// Define MUX_RR_ARBITER_LOCK_EN to hold a grant across a multi-beat packet until in_last.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*W-1:0]       in_data,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic                 out_last,
  output logic [$clog2(N)-1:0] out_src,
  input  logic                 out_ready
);

  localparam int IW = $clog2(N);

  logic [N-1:0]         req, grant;
  logic [IW-1:0]        ptr, idx, idx_inc;
  logic                 slot_free, accept;
  logic [N-1:0][W-1:0]  data_arr;

  assign data_arr = in_data;

`ifdef MUX_RR_ARBITER_LOCK_EN
  state_e        state;
  logic [IW-1:0] lock_k;

  // While locked only the owner of the open packet may be picked.
  assign req = (state == LOCKED) ? (in_valid & (N'(1) << lock_k)) : in_valid;
`else
  assign req = in_valid;
`endif

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .idx   (idx)
  );

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (!rst && slot_free) ? grant : '0;
  assign accept    = |in_ready;
  assign idx_inc   = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= data_arr[idx];
      out_last  <= in_last[idx];
      out_src   <= idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_RR_ARBITER_LOCK_EN
  // ptr only advances when a packet closes; a lock entry leaves it in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      state  <= ARB;
      lock_k <= '0;
    end else if (accept) begin
      if (in_last[idx]) begin
        state <= ARB;
        ptr   <= idx_inc;
      end else if (state == ARB) begin
        state  <= LOCKED;
        lock_k <= idx;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ptr <= '0;
    else if (accept) ptr <= idx_inc;
  end
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter (N=4, W=8): directed scenarios then random traffic,
// all checked against a scan-based round-robin reference model.
module tb_mux_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [1:0]     out_src;
  logic           out_ready;

  int total = 0;
  int bad   = 0;

  // reference model state
  int   m_ptr, m_src, m_k, m_win;
  logic m_ov, m_ol, m_locked, m_acc;
  logic [7:0] m_od;
  logic [N-1:0] exp_rdy;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_ov = 0; m_od = 0; m_ol = 0; m_src = 0;
    m_locked = 0; m_k = 0; m_acc = 0;
  endtask

  // One clock: check ready against the model, take the edge, check the output slot.
  task automatic step();
    logic [N-1:0] elig;
    #1;
    elig = in_valid;
`ifdef MUX_RR_ARBITER_LOCK_EN
    if (m_locked) elig = in_valid & (N'(1) << m_k);
`endif
    m_win   = pick(elig, m_ptr);
    exp_rdy = ((m_ov && !out_ready) || m_win < 0) ? '0 : (N'(1) << m_win);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    m_acc = (exp_rdy != 0);
    if (m_acc) begin
      m_ov  = 1;
      m_od  = in_data[m_win*W +: W];
      m_ol  = in_last[m_win];
      m_src = m_win;
`ifdef MUX_RR_ARBITER_LOCK_EN
      if (!m_locked) begin
        if (!m_ol) begin m_locked = 1; m_k = m_win; end
        else m_ptr = (m_win + 1) % N;
      end else if (m_ol) begin
        m_locked = 0;
        m_ptr = (m_win + 1) % N;
      end
`else
      m_ptr = (m_win + 1) % N;
`endif
    end else if (out_ready) begin
      m_ov = 0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_data", 32'(out_data), 32'(m_od));
      chk("out_last", 32'(out_last), 32'(m_ol));
      chk("out_src",  32'(out_src),  32'(m_src));
    end
  endtask

  task automatic set_seq_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'h10 + 8'(i);
  endtask

  initial begin
    int cnt1;
    logic [7:0] exp_seq [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    int lock_src [4];

    // reset with all requesters asserting
    rst = 1; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1;
    set_seq_data();
    model_reset();
    #3;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_src", 32'(out_src), 0);
    @(posedge clk); #1;
    chk("rst_hold_in_ready", 32'(in_ready), 0);
    chk("rst_hold_out_valid", 32'(out_valid), 0);
    rst = 0;

    // fairness: all four requesting
    for (int s = 0; s < 5; s++) begin
      step();
      chk("fair_onehot", 32'($onehot(in_ready) || !out_ready || in_ready == 0), 1);
      chk("fair_seq", 32'(out_data), 32'(exp_seq[s]));
    end
    step();
    chk("bp_pre", 32'(out_data), 32'h11);

    // backpressure holds the slot
    out_ready = 0;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("bp_ready", 32'(in_ready), 0);
      chk("bp_hold", 32'(out_data), 32'h11);
      chk("bp_valid", 32'(out_valid), 1);
    end
    out_ready = 1;
    step();
    chk("bp_release", 32'(out_data), 32'h12);

    // sparse requests from ptr=3 wrap to 0
    in_valid = 4'b0101;
    step(); chk("wrap_g0", 32'(out_src), 0);
    step(); chk("wrap_g2", 32'(out_src), 2);
    step(); chk("wrap_g0b", 32'(out_src), 0);

    // async reset between edges
    in_valid = 4'b1111;
    #2 rst = 1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    model_reset();
    @(negedge clk) rst = 0;
    step();
    chk("arst_first", 32'(out_src), 0);

    // packet from requester 1 with 0 and 2 competing
    in_valid = 4'b0111;
    cnt1 = 0;
    for (int s = 0; s < 4; s++) begin
      in_last = 4'b1101 | (4'(cnt1 == 2) << 1);
      step();
      lock_src[s] = int'(out_src);
      if (m_acc && m_src == 1) cnt1++;
    end
`ifdef MUX_RR_ARBITER_LOCK_EN
    chk("lock_b0", 32'(lock_src[0]), 1);
    chk("lock_b1", 32'(lock_src[1]), 1);
    chk("lock_b2", 32'(lock_src[2]), 1);
    chk("lock_next", 32'(lock_src[3]), 2);
`else
    chk("nolock_b0", 32'(lock_src[0]), 1);
    chk("nolock_b1", 32'(lock_src[1]), 2);
    chk("nolock_b2", 32'(lock_src[2]), 0);
    chk("nolock_b3", 32'(lock_src[3]), 1);
`endif

    // random traffic against the model
    for (int s = 0; s < 400; s++) begin
      in_valid  = N'($urandom);
      in_last   = N'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
